// File: rtl/l2_ic_responder_pkg.sv
// Shared constants, types and helpers for the L2 instruction-cache refill responder.
package l2_ic_responder_pkg;

   localparam int unsigned L2_LINE_W      = 128;
   localparam int unsigned L2_LINE_ADDR_W = 28;
   localparam int unsigned L2_OFF_W       = 4;

   // Request direction encoding seen on l2_cache_rw
   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } rw_e;

   // Responder FSM encodings
   localparam logic [1:0] L2IC_IDLE   = 2'd0;
   localparam logic [1:0] L2IC_MEM_RD = 2'd1;
   localparam logic [1:0] L2IC_RESP   = 2'd2;

   typedef logic [L2_LINE_ADDR_W-1:0] line_addr_t;

   // Line buffer tag: which line is held and whether it may be reused
   typedef struct packed {
      logic       valid;
      line_addr_t line;
   } buf_tag_t;

   // Byte address of one memory beat inside a line
   function automatic logic [31:0] beat_addr(input line_addr_t line,
                                             input int unsigned beat,
                                             input int unsigned beat_bytes);
      return {line, {L2_OFF_W{1'b0}}} + 32'(beat * beat_bytes);
   endfunction

endpackage

// File: rtl/l2_ic_responder_if.sv
// Icache-side request/response and memory-side beat signals of the refill responder.
interface l2_ic_responder_if
   import l2_ic_responder_pkg::*;
#(
   parameter int unsigned MEM_DATA_W = 32
);

   logic                   irq;
   logic [31:0]            l2_addr;
   logic                   l2_cache_rw;
   logic                   complete;
   logic                   inv_buf;
   logic                   l2_busy;
   logic                   l2_rdy;
   logic                   mem_wr_ic_en;
   logic [L2_LINE_W-1:0]   data_wd_l2;
   logic                   mem_req;
   logic [31:0]            mem_addr;
   logic                   mem_ack;
   logic [MEM_DATA_W-1:0]  mem_rd_data;

   // Responder view
   modport slave (
      input  irq, l2_addr, l2_cache_rw, complete, inv_buf, mem_ack, mem_rd_data,
      output l2_busy, l2_rdy, mem_wr_ic_en, data_wd_l2, mem_req, mem_addr
   );

   // Icache controller / memory view
   modport master (
      output irq, l2_addr, l2_cache_rw, complete, inv_buf, mem_ack, mem_rd_data,
      input  l2_busy, l2_rdy, mem_wr_ic_en, data_wd_l2, mem_req, mem_addr
   );

endinterface

// File: rtl/ic_line_buf.sv
// One-line refill buffer: tag, valid bit and 128-bit data with a beat write port.
module ic_line_buf
   import l2_ic_responder_pkg::*;
#(
   parameter  int unsigned MEM_DATA_W = 32,
   localparam int unsigned BEATS      = L2_LINE_W / MEM_DATA_W,
   localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [CNT_W-1:0]      wr_beat,
   input  logic [MEM_DATA_W-1:0] wr_data,
   input  logic                  fill_done,
   input  line_addr_t            fill_line,
   input  logic                  fill_valid,
   output buf_tag_t              tag,
   output logic [L2_LINE_W-1:0]  line_data
);

   buf_tag_t              tag_q, tag_d;
   logic [L2_LINE_W-1:0]  data_q, data_d;

   // Beat writes land in their slot; a completed fill outranks invalidation
   always_comb begin
      tag_d  = tag_q;
      data_d = data_q;
      if (wr_en) begin
         for (int unsigned b = 0; b < BEATS; b++) begin
            if (wr_beat == CNT_W'(b)) begin
               data_d[b*MEM_DATA_W +: MEM_DATA_W] = wr_data;
            end
         end
      end
      if (fill_done) begin
         tag_d.line  = fill_line;
         tag_d.valid = fill_valid;
      end else if (clr) begin
         tag_d.valid = 1'b0;
      end
   end

   // Buffer state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_q  <= '0;
         data_q <= '0;
      end else begin
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   assign tag       = tag_q;
   assign line_data = data_q;

endmodule

// File: rtl/l2_ic_responder.sv
// L2-side icache refill responder: serves a line from the buffer or by a beat burst from memory.
module l2_ic_responder
   import l2_ic_responder_pkg::*;
#(
   parameter int unsigned MEM_DATA_W = 32
) (
   input logic               clk,
   input logic               reset,
   l2_ic_responder_if.slave  bus
);

   localparam int unsigned     BEATS      = L2_LINE_W / MEM_DATA_W;
   localparam int unsigned     CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned     BEAT_BYTES = MEM_DATA_W / 8;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   line_addr_t            line_q, line_d;
   logic                  inv_seen_q, inv_seen_d;
   logic                  l2_rdy_q, l2_rdy_d;
   logic                  mem_req_q, mem_req_d;
   logic                  busy_q, busy_d;
   logic [31:0]           mem_addr_q, mem_addr_d;

   logic                  miss_start;
   logic                  buf_wr_en;
   logic                  fill_done;
   logic                  fill_valid;
   logic                  hit;
   line_addr_t            req_line;
   buf_tag_t              buf_tag;
   logic [L2_LINE_W-1:0]  buf_data;
   logic [3:0]            unused_addr_off;

   assign req_line        = bus.l2_addr[31:L2_OFF_W];
   assign unused_addr_off = bus.l2_addr[L2_OFF_W-1:0];
   assign hit             = buf_tag.valid && (buf_tag.line == req_line);
   // An invalidate seen anywhere in the burst keeps the fresh line from being reused
   assign fill_valid      = !(inv_seen_q || bus.inv_buf);

   // Next state, beat counter, buffer controls and next registered outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      line_d     = line_q;
      inv_seen_d = inv_seen_q;
      miss_start = 1'b0;
      buf_wr_en  = 1'b0;
      fill_done  = 1'b0;

      case (state_q)
         L2IC_IDLE: begin
            if (bus.irq && (bus.l2_cache_rw == READ)) begin
               line_d = req_line;
               if (hit && !bus.inv_buf) begin
                  state_d = L2IC_RESP;
               end else begin
                  state_d    = L2IC_MEM_RD;
                  cnt_d      = '0;
                  inv_seen_d = 1'b0;
                  miss_start = 1'b1;
               end
            end
         end
         L2IC_MEM_RD: begin
            if (bus.inv_buf) begin
               inv_seen_d = 1'b1;
            end
            if (bus.mem_ack) begin
               buf_wr_en = 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  cnt_d     = '0;
                  fill_done = 1'b1;
                  state_d   = L2IC_RESP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         L2IC_RESP: begin
            if (bus.complete) begin
               state_d = L2IC_IDLE;
            end
         end
         default: begin
            state_d = L2IC_IDLE;
         end
      endcase

      l2_rdy_d   = (state_d == L2IC_RESP);
      mem_req_d  = (state_d == L2IC_MEM_RD);
      busy_d     = (state_d != L2IC_IDLE);
      mem_addr_d = mem_req_d ? beat_addr(line_d, 32'(cnt_d), BEAT_BYTES) : '0;
   end

   // FSM, counter and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= L2IC_IDLE;
         cnt_q      <= '0;
         line_q     <= '0;
         inv_seen_q <= 1'b0;
         l2_rdy_q   <= 1'b0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         line_q     <= line_d;
         inv_seen_q <= inv_seen_d;
         l2_rdy_q   <= l2_rdy_d;
         mem_req_q  <= mem_req_d;
         busy_q     <= busy_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   ic_line_buf #(
      .MEM_DATA_W (MEM_DATA_W)
   ) u_line_buf (
      .clk        (clk),
      .reset      (reset),
      .clr        (bus.inv_buf || miss_start),
      .wr_en      (buf_wr_en),
      .wr_beat    (cnt_q),
      .wr_data    (bus.mem_rd_data),
      .fill_done  (fill_done),
      .fill_line  (line_q),
      .fill_valid (fill_valid),
      .tag        (buf_tag),
      .line_data  (buf_data)
   );

   assign bus.l2_rdy       = l2_rdy_q;
   assign bus.mem_wr_ic_en = l2_rdy_q;
   assign bus.l2_busy      = busy_q;
   assign bus.mem_req      = mem_req_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.data_wd_l2   = buf_data;

endmodule

// File: doc/l2_ic_responder.md
# l2_ic_responder

L2-side responder for instruction-cache refills. Accepts a line request from the icache controller (`irq`, `l2_addr`, `l2_cache_rw`), serves it from a one-line buffer or by burst-reading the backing memory in beats, and returns the 128-bit line on `data_wd_l2` with `l2_rdy` / `mem_wr_ic_en`. It holds the response until the icache reports `complete`. It sits between the IF stage's icache controller and the memory port.

## Interface
- `MEM_DATA_W`, 32, memory beat width; legal values are 32, 64 and 128.
- `BEATS`, `128/MEM_DATA_W`, beats per line; derived, not overridden.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  1  icache refill request; level, held until `l2_rdy`.
- `l2_addr`  in  32  request address; bits [31:4] are the line address.
- `l2_cache_rw`  in  1  must equal `` `READ ``. A request with `` `WRITE `` is ignored.
- `complete`  in  1  icache has written the line to L1.
- `l2_busy`  out  1  responder is not idle.
- `l2_rdy`  out  1  `data_wd_l2` is valid.
- `mem_wr_ic_en`  out  1  icache L1 write enable; equal to `l2_rdy`.
- `data_wd_l2`  out  128  refill line.
- `inv_buf`  in  1  invalidate the line buffer (fence.i / code write).
- `mem_req`  out  1  memory beat request.
- `mem_addr`  out  32  beat address `{line, beat, zeros}`.
- `mem_ack`  in  1  memory beat accepted; `mem_rd_data` is valid in the same cycle.
- `mem_rd_data`  in  `MEM_DATA_W`  beat data.

## Operation
- States are IDLE, MEM_RD and RESP.
- **IDLE.** On `irq && l2_cache_rw==` `READ`, latch `l2_addr[31:4]`.
  - Buffer valid, tag equal and `inv_buf`=0: go to RESP.
  - Otherwise: clear the beat counter and go to MEM_RD.
- **MEM_RD.**
  - `mem_req`=1 with `mem_addr` = {line, beat, 0}.
  - On `mem_ack`, write the beat into the line at `beat*MEM_DATA_W` (beat 0 is the lowest bits) and increment the counter.
  - On the ack of beat `BEATS-1`, set buffer tag to the line and valid to 1, then go to RESP.
  - If `inv_buf` is asserted at any point during MEM_RD, the completed line still goes to the icache, but valid is left 0.
- **RESP.**
  - `l2_rdy`=`mem_wr_ic_en`=1 and `data_wd_l2` = buffer line.
  - On `complete`, go to IDLE.
  - `irq` is ignored while in RESP.
- `l2_busy` = (state != IDLE).
- In IDLE, `inv_buf` clears valid. If `inv_buf` and `irq` arrive together, the request takes the miss path.
- `mem_ack` outside MEM_RD is ignored.

## Timing
- Reset values: state IDLE, valid 0, counter 0. All outputs are 0, including `data_wd_l2`.
- Reset mid-burst or mid-RESP aborts the transfer immediately. `mem_req` drops asynchronously.
- Hit: `irq` sampled at edge T; `l2_rdy` is high from T+1.
- Miss with zero-wait memory: `mem_req` is high in cycles T+1 … T+`BEATS`, and `l2_rdy` is high from T+`BEATS`+1.
- Each memory wait cycle adds one cycle of latency.
- `mem_req` stays high across consecutive beats. `mem_addr` advances on the edge after each ack.
- `l2_rdy` stays high through the cycle in which `complete` is sampled and falls on the next edge. The earliest next request is accepted the cycle after that.
- `data_wd_l2` is stable for the whole time `l2_rdy` is high.

## Structure
- The shared header `l2cache.h` holds:
  - the state encodings (`L2IC_IDLE`, `L2IC_MEM_RD`, `L2IC_RESP`);
  - `L2_LINE_W` = 128 and the line-address width of 28;
  - `` `READ `` / `` `WRITE ``, which stay in `stddef.h`.
- The line buffer (tag, valid, 128-bit data, beat-write port) is a natural sub-module named `ic_line_buf`. The FSM and counter live in `l2_ic_responder`.

## Test plan
- **Cold miss.** Reset, then `irq` with `l2_addr`=0x0000_1040 and zero-wait memory returning 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - `mem_addr` is 0x1040, 0x1044, 0x1048, 0x104C.
  - `l2_rdy` is high at T+5 with `data_wd_l2`=0x44444444_33333333_22222222_11111111.
  - Hold `l2_rdy` until `complete`, then see it low on the next cycle.
- **Buffer hit.** Repeat the request at 0x0000_104C (same line). No `mem_req`; `l2_rdy` is high at T+1 with the same data.
- **Invalidate during burst.** Assert `inv_buf` while beat 2 is pending.
  - The line is still delivered.
  - A following request to the same line misses and issues 4 beats.
- **Wait states.** `mem_ack` is high only every third cycle. `mem_req` stays high and `mem_addr` holds until each ack; `l2_rdy` is high at T+13.
- **Write request and stray ack.** `irq` with `l2_cache_rw`=`` `WRITE `` leaves the responder in IDLE with `l2_busy`=0. A `mem_ack` pulse in IDLE changes nothing.
- **Reset mid-burst.** Assert `reset` low after beat 1. All outputs are 0 and valid is 0; the next request performs a full 4-beat miss.
